// File: rtl/noc_vc_input_fifo_pkg.sv
// rtl/noc_vc_input_fifo_pkg.sv - shared NoC types, configuration and header helpers
package noc_vc_input_fifo_pkg;

    localparam int NOC_MAX_CHANNELS = 8;
    localparam int NOC_MAX_FLIT_W   = 64;

    typedef logic [$clog2(NOC_MAX_CHANNELS)-1:0] vc_idx_t;

    // Flit layout: [flit_width-1] header, [flit_width-2] tail, VC field at vc_lsb.
    typedef struct packed {
        int unsigned flit_width;
        int unsigned vc_lsb;
        int unsigned vc_bits;
    } noc_config_t;

    localparam noc_config_t NOC_DEFAULT_CONFIG = '{flit_width: 32, vc_lsb: 24, vc_bits: 3};

    typedef enum logic {
        IN_IDLE,
        IN_BUSY
    } in_state_t;

    function automatic int noc_occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic vc_idx_t get_vc_index(input logic [NOC_MAX_FLIT_W-1:0] hdr,
                                             input int unsigned vc_lsb,
                                             input int unsigned vc_bits);
        logic [NOC_MAX_FLIT_W-1:0] field;
        field = (hdr >> vc_lsb) & ((NOC_MAX_FLIT_W'(1) << vc_bits) - NOC_MAX_FLIT_W'(1));
        return vc_idx_t'(field);
    endfunction

endpackage

// File: rtl/noc_vc_input_fifo_if.sv
// rtl/noc_vc_input_fifo_if.sv - flit valid/ready channel between NoC stages
interface noc_flit_if
    import noc_vc_input_fifo_pkg::*;
#(
    parameter noc_config_t CONFIG = NOC_DEFAULT_CONFIG
) ();

    logic                          valid;
    logic                          ready;
    logic [CONFIG.flit_width-1:0]  flit;

    modport master (output valid, output flit, input ready);
    modport slave  (input valid, input flit, output ready);

endinterface

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - round-robin arbiter that holds a grant until released
module noc_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] rel,
    output logic [N-1:0] grant
);

    localparam int PTR_W = $clog2(N);

    logic             locked;
    logic [N-1:0]     held;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [N-1:0]     pick;

    // Lowest offset from ptr wins; the inner loop runs high-to-low so the last write is the winner.
    always_comb begin
        pick = '0;
        for (int s = 0; s < N; s++) begin
            if (ptr == PTR_W'(s)) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (req[(s + i) % N]) begin
                        pick = '0;
                        pick[(s + i) % N] = 1'b1;
                    end
                end
            end
        end
    end

    assign grant = locked ? held : pick;

    always_comb begin
        next_ptr = ptr;
        for (int c = 0; c < N; c++) begin
            if (grant[c]) next_ptr = PTR_W'((c + 1) % N);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
            held   <= '0;
            ptr    <= '0;
        end else if (|(grant & rel)) begin
            locked <= 1'b0;
            ptr    <= next_ptr;
        end else if (!locked && |pick) begin
            locked <= 1'b1;
            held   <= pick;
        end
    end

endmodule

// File: rtl/noc_vc_input_fifo_channel.sv
// rtl/noc_vc_input_fifo_channel.sv - one virtual channel: flit storage, counts, eligibility
module noc_vc_input_fifo_channel
    import noc_vc_input_fifo_pkg::*;
#(
    parameter int FLIT_W            = 32,
    parameter int DEPTH             = 8,
    parameter int STORE_AND_FORWARD = 0,
    parameter int OCC_W             = noc_occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [FLIT_W-1:0] wr_flit,
    input  logic              rd_en,
    output logic [FLIT_W-1:0] head_flit,
    output logic              full,
    output logic              empty,
    output logic [OCC_W-1:0]  occupancy,
    output logic [OCC_W-1:0]  packet_count,
    output logic              req
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_tail;
    logic              rd_tail;

    assign head_flit = mem[rd_ptr];
    assign wr_tail   = wr_en && wr_flit[FLIT_W-2];
    assign rd_tail   = rd_en && head_flit[FLIT_W-2];
    assign full      = (occupancy == OCC_W'(DEPTH));
    assign empty     = (occupancy == '0);

    // Store-and-forward holds a header back until its whole packet is resident.
    assign req = !empty && head_flit[FLIT_W-1] &&
                 ((STORE_AND_FORWARD == 0) || (packet_count != '0));

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            packet_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
            case ({wr_tail, rd_tail})
                2'b10:   packet_count <= packet_count + OCC_W'(1);
                2'b01:   packet_count <= packet_count - OCC_W'(1);
                default: packet_count <= packet_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_vc_input_fifo.sv
// rtl/noc_vc_input_fifo.sv - virtual-channel input buffer with packet-granular round-robin output
module noc_vc_input_fifo
    import noc_vc_input_fifo_pkg::*;
#(
    parameter noc_config_t CONFIG            = NOC_DEFAULT_CONFIG,
    parameter int          CHANNELS          = 2,
    parameter int          DEPTH             = 8,
    parameter int          STORE_AND_FORWARD = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    noc_flit_if.slave                         flit_in_if,
    noc_flit_if.master                        flit_out_if,
    output logic [noc_occ_width(DEPTH)-1:0]   o_occupancy    [CHANNELS],
    output logic [noc_occ_width(DEPTH)-1:0]   o_packet_count [CHANNELS],
    output logic                              o_drop
);

    localparam int FW    = int'(CONFIG.flit_width);
    localparam int OCC_W = noc_occ_width(DEPTH);

    in_state_t         state;
    vc_idx_t           cur_vc;
    vc_idx_t           raw_vc;
    vc_idx_t           hdr_vc;
    vc_idx_t           target;
    logic              is_hdr;
    logic              in_tail;
    logic              orphan;
    logic              tgt_full;
    logic              accept;

    logic [CHANNELS-1:0] wr_en;
    logic [CHANNELS-1:0] rd_en;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] rel;
    logic [FW-1:0]       head_flit [CHANNELS];
    logic [FW-1:0]       out_flit;
    logic                sel_empty;
    logic                out_valid;
    logic                xfer;

    assign is_hdr  = flit_in_if.flit[FW-1];
    assign in_tail = flit_in_if.flit[FW-2];
    assign raw_vc  = get_vc_index(NOC_MAX_FLIT_W'(flit_in_if.flit), CONFIG.vc_lsb, CONFIG.vc_bits);
    assign hdr_vc  = vc_idx_t'(32'(raw_vc) % 32'(CHANNELS));
    assign target  = (state == IN_BUSY) ? cur_vc : hdr_vc;
    assign orphan  = (state == IN_IDLE) && !is_hdr;

    always_comb begin
        tgt_full = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (target == vc_idx_t'(c)) tgt_full = full[c];
        end
    end

    // Orphans are always swallowed so a stray body flit can never stall the link.
    assign flit_in_if.ready = !rst && (orphan || !tgt_full);
    assign accept           = flit_in_if.valid && flit_in_if.ready;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            wr_en[c] = accept && !orphan && (target == vc_idx_t'(c));
            rd_en[c] = xfer && grant[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IN_IDLE;
            cur_vc <= '0;
            o_drop <= 1'b0;
        end else begin
            o_drop <= accept && orphan;
            case (state)
                IN_IDLE: begin
                    if (accept && is_hdr && !in_tail) begin
                        state  <= IN_BUSY;
                        cur_vc <= hdr_vc;
                    end
                end
                IN_BUSY: begin
                    if (accept && in_tail) state <= IN_IDLE;
                end
                default: state <= IN_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        noc_vc_input_fifo_channel #(
            .FLIT_W            (FW),
            .DEPTH             (DEPTH),
            .STORE_AND_FORWARD (STORE_AND_FORWARD),
            .OCC_W             (OCC_W)
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (wr_en[g]),
            .wr_flit      (flit_in_if.flit),
            .rd_en        (rd_en[g]),
            .head_flit    (head_flit[g]),
            .full         (full[g]),
            .empty        (empty[g]),
            .occupancy    (o_occupancy[g]),
            .packet_count (o_packet_count[g]),
            .req          (req[g])
        );
    end

    noc_rr_arbiter #(
        .N (CHANNELS)
    ) u_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .rel   (rel),
        .grant (grant)
    );

    always_comb begin
        out_flit  = '0;
        sel_empty = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant[c]) begin
                out_flit  = head_flit[c];
                sel_empty = empty[c];
            end
        end
    end

    assign out_valid         = !rst && !sel_empty;
    assign xfer              = out_valid && flit_out_if.ready;
    assign rel               = grant & {CHANNELS{xfer && out_flit[FW-2]}};
    assign flit_out_if.valid = out_valid;
    assign flit_out_if.flit  = out_flit;

endmodule

// File: tb/tb_noc_vc_input_fifo.sv
// tb/tb_noc_vc_input_fifo.sv - scoreboard bench for cut-through and store-and-forward VC buffers
module tb_noc_vc_input_fifo;
    import noc_vc_input_fifo_pkg::*;

    localparam noc_config_t TB_CFG = '{flit_width: 16, vc_lsb: 8, vc_bits: 3};

    logic clk;
    logic rst;

    noc_flit_if #(.CONFIG(TB_CFG)) in_a  ();
    noc_flit_if #(.CONFIG(TB_CFG)) out_a ();
    noc_flit_if #(.CONFIG(TB_CFG)) in_b  ();
    noc_flit_if #(.CONFIG(TB_CFG)) out_b ();

    logic [2:0] occ_a [4];
    logic [2:0] pkt_a [4];
    logic [2:0] occ_b [4];
    logic [2:0] pkt_b [4];
    logic       drop_a;
    logic       drop_b;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];

    noc_vc_input_fifo #(
        .CONFIG(TB_CFG), .CHANNELS(4), .DEPTH(4), .STORE_AND_FORWARD(0)
    ) dut_a (
        .clk            (clk),
        .rst            (rst),
        .flit_in_if     (in_a),
        .flit_out_if    (out_a),
        .o_occupancy    (occ_a),
        .o_packet_count (pkt_a),
        .o_drop         (drop_a)
    );

    noc_vc_input_fifo #(
        .CONFIG(TB_CFG), .CHANNELS(4), .DEPTH(4), .STORE_AND_FORWARD(1)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .flit_in_if     (in_b),
        .flit_out_if    (out_b),
        .o_occupancy    (occ_b),
        .o_packet_count (pkt_b),
        .o_drop         (drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic h, input logic t,
                                       input logic [2:0] vc, input logic [7:0] p);
        return {h, t, 3'b000, vc, p};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_a.valid && out_a.ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_a_unexpected actual=%h expected=none", out_a.flit);
            end else begin
                chk("out_a_flit", int'(out_a.flit), int'(exp_a.pop_front()));
            end
        end
        if (!rst && out_b.valid && out_b.ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_b_unexpected actual=%h expected=none", out_b.flit);
            end else begin
                chk("out_b_flit", int'(out_b.flit), int'(exp_b.pop_front()));
            end
        end
    end

    task automatic send(input bit to_b, input logic [15:0] f);
        int n;
        n = 0;
        if (to_b) begin
            in_b.flit  = f;
            in_b.valid = 1'b1;
        end else begin
            in_a.flit  = f;
            in_a.valid = 1'b1;
        end
        @(negedge clk);
        while (!(to_b ? in_b.ready : in_a.ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", int'(to_b ? in_b.ready : in_a.ready), 1);
        @(posedge clk);
        #1;
        in_a.valid = 1'b0;
        in_b.valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_remaining", exp_a.size() + exp_b.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int s;
        rst         = 1'b1;
        in_a.valid  = 1'b0;
        in_a.flit   = '0;
        in_b.valid  = 1'b0;
        in_b.flit   = '0;
        out_a.ready = 1'b0;
        out_b.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_a.ready), 0);
        chk("rst_out_valid", int'(out_a.valid), 0);
        chk("rst_drop", int'(drop_a), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_a.ready), 1);
        chk("post_rst_out_valid", int'(out_a.valid), 0);
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_occ", int'(occ_a[c]), 0);
            chk("post_rst_pkt", int'(pkt_a[c]), 0);
        end
        @(posedge clk);
        #1;

        // 5-flit packet into a 4-deep channel with the output stalled
        exp_a.push_back(mk(1, 0, 2, 8'h20));
        send(0, mk(1, 0, 2, 8'h20));
        chk("ct_valid_after_hdr", int'(out_a.valid), 1);
        for (int i = 1; i < 4; i++) begin
            exp_a.push_back(mk(0, 0, 0, 8'(8'h20 + i)));
            send(0, mk(0, 0, 0, 8'(8'h20 + i)));
        end
        chk("full_occ2", int'(occ_a[2]), 4);
        chk("full_in_ready", int'(in_a.ready), 0);
        chk("full_pkt2", int'(pkt_a[2]), 0);
        out_a.ready = 1'b1;
        exp_a.push_back(mk(0, 1, 0, 8'h24));
        send(0, mk(0, 1, 0, 8'h24));
        wait_drain();
        chk("long_occ2_after", int'(occ_a[2]), 0);
        chk("long_pkt2_after", int'(pkt_a[2]), 0);

        // orphan body flit while idle
        send(0, mk(0, 0, 1, 8'h55));
        chk("drop_pulse", int'(drop_a), 1);
        s = 0;
        for (int c = 0; c < 4; c++) s += int'(occ_a[c]);
        chk("drop_occ_sum", s, 0);
        @(posedge clk);
        #1;
        chk("drop_one_cycle", int'(drop_a), 0);

        // reset with half a packet stored
        out_a.ready = 1'b0;
        send(0, mk(1, 0, 1, 8'h30));
        send(0, mk(0, 0, 0, 8'h31));
        chk("mid_occ1", int'(occ_a[1]), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", int'(out_a.valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("after_rst_occ1", int'(occ_a[1]), 0);
        chk("after_rst_valid", int'(out_a.valid), 0);

        // three channels loaded, round-robin from channel 0
        exp_a.push_back(mk(1, 0, 0, 8'h40));
        exp_a.push_back(mk(0, 1, 0, 8'h41));
        exp_a.push_back(mk(1, 0, 1, 8'h50));
        exp_a.push_back(mk(0, 1, 0, 8'h51));
        exp_a.push_back(mk(1, 0, 3, 8'h70));
        exp_a.push_back(mk(0, 1, 0, 8'h71));
        exp_a.push_back(mk(1, 1, 0, 8'h42));
        send(0, mk(1, 0, 0, 8'h40));
        send(0, mk(0, 1, 0, 8'h41));
        send(0, mk(1, 0, 1, 8'h50));
        send(0, mk(0, 1, 0, 8'h51));
        send(0, mk(1, 0, 3, 8'h70));
        send(0, mk(0, 1, 0, 8'h71));
        send(0, mk(1, 1, 0, 8'h42));
        chk("rr_occ0", int'(occ_a[0]), 3);
        chk("rr_occ1", int'(occ_a[1]), 2);
        chk("rr_occ3", int'(occ_a[3]), 2);
        chk("rr_pkt0", int'(pkt_a[0]), 2);
        out_a.ready = 1'b1;
        wait_drain();

        // tail write and tail read on channel 1 in the same cycle
        out_a.ready = 1'b0;
        exp_a.push_back(mk(1, 0, 1, 8'h60));
        exp_a.push_back(mk(0, 1, 0, 8'h61));
        exp_a.push_back(mk(1, 0, 1, 8'h62));
        exp_a.push_back(mk(0, 1, 0, 8'h63));
        send(0, mk(1, 0, 1, 8'h60));
        send(0, mk(0, 1, 0, 8'h61));
        send(0, mk(1, 0, 1, 8'h62));
        chk("same_pkt1_before", int'(pkt_a[1]), 1);
        chk("same_occ1_before", int'(occ_a[1]), 3);
        out_a.ready = 1'b1;
        @(posedge clk);
        #1;
        chk("same_occ1_hdr_read", int'(occ_a[1]), 2);
        send(0, mk(0, 1, 0, 8'h63));
        chk("same_pkt1_after", int'(pkt_a[1]), 1);
        chk("same_occ1_after", int'(occ_a[1]), 2);
        wait_drain();
        chk("same_pkt1_drained", int'(pkt_a[1]), 0);

        // store-and-forward: nothing leaves before the tail is stored
        out_b.ready = 1'b1;
        exp_b.push_back(mk(1, 0, 3, 8'h80));
        exp_b.push_back(mk(0, 0, 0, 8'h81));
        exp_b.push_back(mk(0, 1, 0, 8'h82));
        send(1, mk(1, 0, 3, 8'h80));
        chk("saf_valid_after_hdr", int'(out_b.valid), 0);
        chk("saf_pkt3_hdr", int'(pkt_b[3]), 0);
        send(1, mk(0, 0, 0, 8'h81));
        chk("saf_valid_after_body", int'(out_b.valid), 0);
        send(1, mk(0, 1, 0, 8'h82));
        chk("saf_pkt3_tail", int'(pkt_b[3]), 1);
        chk("saf_valid_after_tail", int'(out_b.valid), 1);
        wait_drain();
        chk("saf_pkt3_drained", int'(pkt_b[3]), 0);
        chk("saf_occ3_drained", int'(occ_b[3]), 0);

        chk("final_exp_a_empty", exp_a.size(), 0);
        chk("final_exp_b_empty", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
